// File: rtl/max_tree64.sv
// Pipelined signed-max reduction tree over 64 x Q5.10 lanes, with delay-matched bypass of the input vector.
// Define MAX_TREE_IN_REG_EN to add an input register stage (latency 4 instead of 3).
module max_tree64 (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic [1:0]    i_length_mode,
  input  logic [63:0]   i_valid,
  input  logic [1023:0] i_in_flat,
  output logic          o_valid_max,
  output logic [15:0]   o_max64_0,
  output logic [15:0]   o_max32_0,
  output logic [15:0]   o_max32_1,
  output logic [15:0]   o_max16_0,
  output logic [15:0]   o_max16_1,
  output logic [15:0]   o_max16_2,
  output logic [15:0]   o_max16_3,
  output logic [1:0]    o_length_mode_byp,
  output logic [63:0]   o_valid_byp,
  output logic [1023:0] o_in_byp
);

  localparam int DW = 16;
  localparam int N  = 64;

  typedef logic signed [DW-1:0] lane_t;
  localparam lane_t LANE_MIN = 16'sh8000;

  function automatic lane_t smax(input lane_t a, input lane_t b);
    return (a > b) ? a : b;
  endfunction

  logic [1:0]      f_mode;
  logic [N-1:0]    f_valid;
  logic [N*DW-1:0] f_data;

`ifdef MAX_TREE_IN_REG_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      f_mode  <= '0;
      f_valid <= '0;
      f_data  <= '0;
    end else if (i_en) begin
      f_mode  <= i_length_mode;
      f_valid <= i_valid;
      f_data  <= i_in_flat;
    end
  end
`else
  assign f_mode  = i_length_mode;
  assign f_valid = i_valid;
  assign f_data  = i_in_flat;
`endif

  // Invalid lanes enter as the most negative value so they can never win.
  lane_t lane_m [N];
  always_comb begin
    for (int i = 0; i < N; i++)
      lane_m[i] = f_valid[i] ? lane_t'(f_data[i*DW +: DW]) : LANE_MIN;
  end

  // NOTE: every element is assigned on every pass, so no latch is inferred.
  lane_t lvl1 [32];
  always_comb begin
    for (int i = 0; i < 32; i++) lvl1[i] = smax(lane_m[2*i], lane_m[2*i+1]);
  end

  lane_t lvl2 [16];
  always_comb begin
    for (int i = 0; i < 16; i++) lvl2[i] = smax(lvl1[2*i], lvl1[2*i+1]);
  end

  lane_t           s1_max [16];
  lane_t           s2_max [4];
  logic            s1_any, s2_any;
  logic [1:0]      s1_mode, s2_mode;
  logic [N-1:0]    s1_valid, s2_valid;
  logic [N*DW-1:0] s1_data, s2_data;

  lane_t lvl3 [8];
  lane_t lvl4 [4];
  always_comb begin
    for (int i = 0; i < 8; i++) lvl3[i] = smax(s1_max[2*i], s1_max[2*i+1]);
  end
  always_comb begin
    for (int i = 0; i < 4; i++) lvl4[i] = smax(lvl3[2*i], lvl3[2*i+1]);
  end

  lane_t lvl5_0, lvl5_1, lvl6;
  always_comb begin
    lvl5_0 = smax(s2_max[0], s2_max[1]);
    lvl5_1 = smax(s2_max[2], s2_max[3]);
    lvl6   = smax(lvl5_0, lvl5_1);
  end

  // NOTE: sequential state uses non-blocking assignments so stages shift together on one edge.
  // NOTE: the maxima arrays are pipeline registers, not storage, so they are reset with the rest.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 16; i++) s1_max[i] <= '0;
      for (int i = 0; i < 4; i++)  s2_max[i] <= '0;
      s1_any            <= 1'b0;
      s2_any            <= 1'b0;
      s1_mode           <= '0;
      s2_mode           <= '0;
      s1_valid          <= '0;
      s2_valid          <= '0;
      s1_data           <= '0;
      s2_data           <= '0;
      o_valid_max       <= 1'b0;
      o_max64_0         <= '0;
      o_max32_0         <= '0;
      o_max32_1         <= '0;
      o_max16_0         <= '0;
      o_max16_1         <= '0;
      o_max16_2         <= '0;
      o_max16_3         <= '0;
      o_length_mode_byp <= '0;
      o_valid_byp       <= '0;
      o_in_byp          <= '0;
    end else if (i_en) begin
      for (int i = 0; i < 16; i++) s1_max[i] <= lvl2[i];
      s1_any   <= |f_valid;
      s1_mode  <= f_mode;
      s1_valid <= f_valid;
      s1_data  <= f_data;

      for (int i = 0; i < 4; i++) s2_max[i] <= lvl4[i];
      s2_any   <= s1_any;
      s2_mode  <= s1_mode;
      s2_valid <= s1_valid;
      s2_data  <= s1_data;

      o_max16_0         <= s2_max[0];
      o_max16_1         <= s2_max[1];
      o_max16_2         <= s2_max[2];
      o_max16_3         <= s2_max[3];
      o_max32_0         <= lvl5_0;
      o_max32_1         <= lvl5_1;
      o_max64_0         <= lvl6;
      o_valid_max       <= s2_any;
      o_length_mode_byp <= s2_mode;
      o_valid_byp       <= s2_valid;
      o_in_byp          <= s2_data;
    end
  end

endmodule

// File: tb/tb_max_tree64.sv
// Self-checking bench for max_tree64: table-driven streamed vectors plus stall and mid-flight reset sequences.
module tb_max_tree64;

`ifdef MAX_TREE_IN_REG_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif
  localparam int NV = 7;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [1:0]    length_mode;
  logic [63:0]   valid;
  logic [1023:0] in_flat;
  logic          valid_max;
  logic [15:0]   max64_0, max32_0, max32_1, max16_0, max16_1, max16_2, max16_3;
  logic [1:0]    length_mode_byp;
  logic [63:0]   valid_byp;
  logic [1023:0] in_byp;

  max_tree64 dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_en              (en),
    .i_length_mode     (length_mode),
    .i_valid           (valid),
    .i_in_flat         (in_flat),
    .o_valid_max       (valid_max),
    .o_max64_0         (max64_0),
    .o_max32_0         (max32_0),
    .o_max32_1         (max32_1),
    .o_max16_0         (max16_0),
    .o_max16_1         (max16_1),
    .o_max16_2         (max16_2),
    .o_max16_3         (max16_3),
    .o_length_mode_byp (length_mode_byp),
    .o_valid_byp       (valid_byp),
    .o_in_byp          (in_byp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1023:0] data;
    logic [63:0]   valid;
    logic [1:0]    mode;
    logic          vmax;
    logic [15:0]   e64, e32_0, e32_1, e16_0, e16_1, e16_2, e16_3;
  } vec_t;

  vec_t tbl [NV];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_vec(input vec_t v, input string tag);
    check({tag, " valid_max"}, 64'(valid_max), 64'(v.vmax));
    check({tag, " max64"},     64'(max64_0),   64'(v.e64));
    check({tag, " max32_0"},   64'(max32_0),   64'(v.e32_0));
    check({tag, " max32_1"},   64'(max32_1),   64'(v.e32_1));
    check({tag, " max16_0"},   64'(max16_0),   64'(v.e16_0));
    check({tag, " max16_1"},   64'(max16_1),   64'(v.e16_1));
    check({tag, " max16_2"},   64'(max16_2),   64'(v.e16_2));
    check({tag, " max16_3"},   64'(max16_3),   64'(v.e16_3));
    check({tag, " mode_byp"},  64'(length_mode_byp), 64'(v.mode));
    check({tag, " valid_byp"}, valid_byp,      v.valid);
    check({tag, " in_byp_match"}, 64'(in_byp === v.data), 64'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " valid_max"}, 64'(valid_max), 64'd0);
    check({tag, " max64"},     64'(max64_0),   64'd0);
    check({tag, " max32"},     64'({max32_0, max32_1}), 64'd0);
    check({tag, " max16"},     {max16_0, max16_1, max16_2, max16_3}, 64'd0);
    check({tag, " mode_byp"},  64'(length_mode_byp), 64'd0);
    check({tag, " valid_byp"}, valid_byp,      64'd0);
    check({tag, " in_byp_zero"}, 64'(in_byp === '0), 64'd1);
  endtask

  task automatic drive(input vec_t v);
    in_flat     = v.data;
    valid       = v.valid;
    length_mode = v.mode;
  endtask

  task automatic drive_idle();
    in_flat     = '0;
    valid       = '0;
    length_mode = 2'd0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int npulse;

    // Directed vectors with hand-computed expectations.
    for (int k = 0; k < 64; k++) tbl[0].data[k*16 +: 16] = 16'(k);
    tbl[0].data[15:0] = 16'd500;
    tbl[0].valid = '1; tbl[0].mode = 2'd0; tbl[0].vmax = 1'b1;
    tbl[0].e64 = 16'd500; tbl[0].e32_0 = 16'd500; tbl[0].e32_1 = 16'd63;
    tbl[0].e16_0 = 16'd500; tbl[0].e16_1 = 16'd31; tbl[0].e16_2 = 16'd47; tbl[0].e16_3 = 16'd63;

    for (int k = 0; k < 64; k++) tbl[1].data[k*16 +: 16] = 16'd10;
    tbl[1].data[63*16 +: 16] = 16'd999;
    tbl[1].valid = '1; tbl[1].mode = 2'd1; tbl[1].vmax = 1'b1;
    tbl[1].e64 = 16'd999; tbl[1].e32_0 = 16'd10; tbl[1].e32_1 = 16'd999;
    tbl[1].e16_0 = 16'd10; tbl[1].e16_1 = 16'd10; tbl[1].e16_2 = 16'd10; tbl[1].e16_3 = 16'd999;

    for (int k = 0; k < 64; k++) tbl[2].data[k*16 +: 16] = 16'(-100 + k);
    tbl[2].valid = '1; tbl[2].mode = 2'd2; tbl[2].vmax = 1'b1;
    tbl[2].e64 = 16'(-37); tbl[2].e32_0 = 16'(-69); tbl[2].e32_1 = 16'(-37);
    tbl[2].e16_0 = 16'(-85); tbl[2].e16_1 = 16'(-69); tbl[2].e16_2 = 16'(-53); tbl[2].e16_3 = 16'(-37);

    for (int k = 0; k < 64; k++) tbl[3].data[k*16 +: 16] = 16'(-500 - k);
    tbl[3].data[10*16 +: 16] = 16'(-5);
    tbl[3].valid = '1; tbl[3].mode = 2'd0; tbl[3].vmax = 1'b1;
    tbl[3].e64 = 16'(-5); tbl[3].e32_0 = 16'(-5); tbl[3].e32_1 = 16'(-532);
    tbl[3].e16_0 = 16'(-5); tbl[3].e16_1 = 16'(-516); tbl[3].e16_2 = 16'(-532); tbl[3].e16_3 = 16'(-548);

    for (int k = 0; k < 64; k++) tbl[4].data[k*16 +: 16] = 16'd999;
    tbl[4].data[40*16 +: 16] = 16'd7;
    tbl[4].valid = 64'd1 << 40; tbl[4].mode = 2'd0; tbl[4].vmax = 1'b1;
    tbl[4].e64 = 16'd7; tbl[4].e32_0 = 16'h8000; tbl[4].e32_1 = 16'd7;
    tbl[4].e16_0 = 16'h8000; tbl[4].e16_1 = 16'h8000; tbl[4].e16_2 = 16'd7; tbl[4].e16_3 = 16'h8000;

    for (int k = 0; k < 64; k++) tbl[5].data[k*16 +: 16] = 16'(k * 3);
    tbl[5].valid = '0; tbl[5].mode = 2'd1; tbl[5].vmax = 1'b0;
    tbl[5].e64 = 16'h8000; tbl[5].e32_0 = 16'h8000; tbl[5].e32_1 = 16'h8000;
    tbl[5].e16_0 = 16'h8000; tbl[5].e16_1 = 16'h8000; tbl[5].e16_2 = 16'h8000; tbl[5].e16_3 = 16'h8000;

    for (int k = 0; k < 64; k++) tbl[6].data[k*16 +: 16] = 16'h8000;
    tbl[6].data[20*16 +: 16] = 16'h7FFF;
    tbl[6].valid = '1; tbl[6].mode = 2'd2; tbl[6].vmax = 1'b1;
    tbl[6].e64 = 16'h7FFF; tbl[6].e32_0 = 16'h7FFF; tbl[6].e32_1 = 16'h8000;
    tbl[6].e16_0 = 16'h8000; tbl[6].e16_1 = 16'h7FFF; tbl[6].e16_2 = 16'h8000; tbl[6].e16_3 = 16'h8000;

    // Reset state.
    rst_n = 1'b0;
    en    = 1'b0;
    drive_idle();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    en    = 1'b1;

    // Stream all vectors back-to-back; vector j appears LAT negedges after it is driven.
    for (int c = 0; c < NV + LAT; c++) begin
      @(negedge clk);
      if (c >= LAT) check_vec(tbl[c - LAT], $sformatf("vec%0d", c - LAT));
      if (c < NV) drive(tbl[c]);
      else drive_idle();
    end
    repeat (LAT + 1) @(negedge clk);
    check("idle valid_max", 64'(valid_max), 64'd0);

    // Two back-to-back vectors, then a 2-cycle stall with a foreign vector on the inputs.
    drive(tbl[0]);
    @(negedge clk);
    drive(tbl[1]);
    @(negedge clk);
    en = 1'b0;
    drive(tbl[4]);
    @(negedge clk);
    @(negedge clk);
    check("stall valid_max held", 64'(valid_max), 64'd0);
    en = 1'b1;
    drive_idle();
    npulse = 0;
    for (int c = 0; c < LAT + 8; c++) begin
      @(negedge clk);
      if (valid_max) begin
        if (npulse == 0) check_vec(tbl[0], "stall_a");
        else if (npulse == 1) check_vec(tbl[1], "stall_b");
        npulse++;
      end
    end
    check("stall pulse count", 64'(npulse), 64'd2);

    // Fill the pipeline, then assert reset asynchronously mid-cycle.
    for (int c = 0; c <= LAT; c++) begin
      drive(tbl[c]);
      @(negedge clk);
    end
    check("pre-reset valid_max", 64'(valid_max), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_zero("midreset");
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    npulse = 0;
    for (int c = 0; c < LAT + 3; c++) begin
      @(negedge clk);
      if (valid_max) npulse++;
    end
    check("post-reset pulse count", 64'(npulse), 64'd0);
    check("post-reset max64", 64'(max64_0), 64'h8000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
